// File: rtl/washer_plant_model.sv
// washer_plant_model: behavioural model of the washing-machine drum, valves and
// level sensor, driven by the controller's actuator outputs. It returns the
// sensor-side view and latches sticky overflow / wet-spin faults.
// Optional build macro WASHER_PLANT_LEAK_EN adds a slow free-running leak that
// bleeds one level step every LEAK_DIV cycles.
module washer_plant_model #(
  parameter int LEVEL_MAX = 12,
  parameter int FILL_DIV  = 4,
  parameter int DRAIN_DIV = 2,
  parameter int SPIN_UP   = 8,
  parameter int WET_MAX   = 2
`ifdef WASHER_PLANT_LEAK_EN
  , parameter int LEAK_DIV = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       agitator,
  input  logic       motor,
  input  logic       pump,
  input  logic       speed,
  input  logic       water,
  input  logic [1:0] load,
  output logic [3:0] level,
  output logic       full,
  output logic       empty,
  output logic [1:0] drum_state,
  output logic       spin_ok,
  output logic       spin_hi,
  output logic [1:0] fault
);

  localparam logic [1:0] MODE_HOLD  = 2'd0;
  localparam logic [1:0] MODE_FILL  = 2'd1;
  localparam logic [1:0] MODE_DRAIN = 2'd2;

  localparam logic [1:0] ST_STOP    = 2'd0;
  localparam logic [1:0] ST_AGITATE = 2'd1;
  localparam logic [1:0] ST_RAMP    = 2'd2;
  localparam logic [1:0] ST_SPIN    = 2'd3;

  localparam logic [3:0] LVL_MAX    = 4'(LEVEL_MAX);
  localparam logic [3:0] WET_LVL    = 4'(WET_MAX);
  localparam logic [7:0] FILL_LAST  = 8'(FILL_DIV - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_DIV - 1);
  localparam logic [7:0] RAMP_LAST  = 8'(SPIN_UP - 1);

  logic [3:0] level_q, level_d;
  logic [7:0] presc_q, presc_d;
  logic [1:0] mode_q, mode_d;
  logic [1:0] drum_q, drum_d;
  logic [7:0] ramp_q, ramp_d;
  logic       spin_hi_q, spin_hi_d;
  logic [1:0] fault_q, fault_d;

  logic [7:0] presc_eff;
  logic       fill_step;
  logic       drain_step;
  logic       leak_tick;
  logic       overflow;
  logic       wet_spin;
  logic [4:0] target_raw;
  logic [3:0] target;

`ifdef WASHER_PLANT_LEAK_EN
  localparam logic [15:0] LEAK_LAST = 16'(LEAK_DIV - 1);
  logic [15:0] leak_q, leak_d;

  // Free-running leak counter; only reset clears it, fluid mode does not.
  always_comb begin
    leak_tick = (leak_q == LEAK_LAST);
    leak_d    = leak_tick ? 16'd0 : leak_q + 16'd1;
  end

  // Leak counter register.
  always_ff @(posedge clk) begin
    if (reset) leak_q <= 16'd0;
    else       leak_q <= leak_d;
  end
`else
  // No leak in the default build.
  always_comb begin
    leak_tick = 1'b0;
  end
`endif

  // Fluid path: decode mode, run the prescaler, and step the level.
  always_comb begin
    mode_d = MODE_HOLD;
    if (water && !pump)      mode_d = MODE_FILL;
    else if (pump && !water) mode_d = MODE_DRAIN;

    // A mode change restarts the count on this very edge, so the first
    // step still lands on the DIV-th edge of the new mode.
    presc_eff  = (mode_d != mode_q) ? 8'd0 : presc_q;
    fill_step  = 1'b0;
    drain_step = 1'b0;
    presc_d    = 8'd0;
    case (mode_d)
      MODE_FILL: begin
        if (presc_eff == FILL_LAST) fill_step = 1'b1;
        else                        presc_d   = presc_eff + 8'd1;
      end
      MODE_DRAIN: begin
        if (presc_eff == DRAIN_LAST) drain_step = 1'b1;
        else                         presc_d    = presc_eff + 8'd1;
      end
      default: presc_d = 8'd0;
    endcase

    // Overflow is the fill step that would have gone past the top.
    overflow = fill_step && (level_q == LVL_MAX);

    level_d = level_q;
    if (fill_step && leak_tick) begin
      level_d = level_q;
    end else if (fill_step) begin
      if (level_q != LVL_MAX) level_d = level_q + 4'd1;
    end else if (drain_step || leak_tick) begin
      if (level_q != 4'd0) level_d = level_q - 4'd1;
    end
  end

  // Drum FSM: motor/agitator select the state, speed changes restart the ramp.
  always_comb begin
    drum_d    = drum_q;
    ramp_d    = ramp_q;
    spin_hi_d = spin_hi_q;
    wet_spin  = 1'b0;
    if (!motor) begin
      drum_d = ST_STOP;
      ramp_d = 8'd0;
    end else if (agitator) begin
      drum_d = ST_AGITATE;
      ramp_d = 8'd0;
    end else begin
      case (drum_q)
        ST_RAMP: begin
          if (speed != spin_hi_q) begin
            ramp_d    = 8'd0;
            spin_hi_d = speed;
          end else if (ramp_q == RAMP_LAST) begin
            drum_d   = ST_SPIN;
            ramp_d   = 8'd0;
            wet_spin = (level_q > WET_LVL);
          end else begin
            ramp_d = ramp_q + 8'd1;
          end
        end
        ST_SPIN: begin
          if (speed != spin_hi_q) begin
            drum_d    = ST_RAMP;
            ramp_d    = 8'd0;
            spin_hi_d = speed;
          end
        end
        default: begin
          drum_d    = ST_RAMP;
          ramp_d    = 8'd0;
          spin_hi_d = speed;
        end
      endcase
    end
  end

  // Sticky faults: both bits may latch on the same edge.
  always_comb begin
    fault_d = fault_q | {wet_spin, overflow};
  end

  // State registers for fluid, drum and fault paths.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q   <= 4'd0;
      presc_q   <= 8'd0;
      mode_q    <= MODE_HOLD;
      drum_q    <= ST_STOP;
      ramp_q    <= 8'd0;
      spin_hi_q <= 1'b0;
      fault_q   <= 2'b00;
    end else begin
      level_q   <= level_d;
      presc_q   <= presc_d;
      mode_q    <= mode_d;
      drum_q    <= drum_d;
      ramp_q    <= ramp_d;
      spin_hi_q <= spin_hi_d;
      fault_q   <= fault_d;
    end
  end

  // Fill target from load size: 4 / 8 / 12 / 12.
  always_comb begin
    target_raw = {1'b0, load, 2'b00} + 5'd4;
    target     = (target_raw > {1'b0, LVL_MAX}) ? LVL_MAX : target_raw[3:0];
  end

  assign level      = level_q;
  assign full       = (level_q >= target);
  assign empty      = (level_q == 4'd0);
  assign drum_state = drum_q;
  assign spin_ok    = (drum_q == ST_SPIN);
  assign spin_hi    = spin_hi_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_washer_plant_model.sv
// Self-checking bench for washer_plant_model. Each scenario task pushes the
// expected sensor vector into a scoreboard queue before the edge and pops and
// compares it against the DUT one time unit after the edge.
module tb_washer_plant_model;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       agitator = 1'b0;
  logic       motor = 1'b0;
  logic       pump = 1'b0;
  logic       speed = 1'b0;
  logic       water = 1'b0;
  logic [1:0] load = 2'd0;
  logic [3:0] level;
  logic       full;
  logic       empty;
  logic [1:0] drum_state;
  logic       spin_ok;
  logic       spin_hi;
  logic [1:0] fault;

  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] sb_q[$];
  logic [11:0] got;
  logic [11:0] ev;

  washer_plant_model dut (
    .clk(clk), .reset(reset), .agitator(agitator), .motor(motor),
    .pump(pump), .speed(speed), .water(water), .load(load),
    .level(level), .full(full), .empty(empty), .drum_state(drum_state),
    .spin_ok(spin_ok), .spin_hi(spin_hi), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected vector {level, full, empty, drum, spin_ok, spin_hi, fault}
  function automatic logic [11:0] exp_vec(input int lvl, input int ld,
                                          input int drum, input logic hi,
                                          input int flt);
    int tgt;
    tgt = 4 * (ld + 1);
    if (tgt > 12) tgt = 12;
    return {4'(lvl), (lvl >= tgt), (lvl == 0), 2'(drum), (drum == 3), hi, 2'(flt)};
  endfunction

  function automatic logic [11:0] obs();
    return {level, full, empty, drum_state, spin_ok, spin_hi, fault};
  endfunction

  task automatic drive_idle();
    agitator = 1'b0; motor = 1'b0; pump = 1'b0; speed = 1'b0; water = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Prep only: hold water open for n edges.
  task automatic fill_edges(input int n);
    water = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    water = 1'b0;
  endtask

  task automatic test_reset();
    load = 2'd0;
    reset = 1'b0;
    water = 1'b1; motor = 1'b1; speed = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    // Reset mid-activity with inputs still active, held two edges.
    reset = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      if (e == 3) begin reset = 1'b0; drive_idle(); end
      sb_q.push_back(exp_vec(0, 0, 0, 1'b0, 0));
      @(posedge clk); #1;
      got = obs(); ev = sb_q.pop_front(); n_checks++;
      if (got !== ev) begin
        n_errors++;
        $display("FAIL reset edge=%0d got=%h exp=%h", e, got, ev);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_fill();
    do_reset();
    load = 2'd1; water = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      sb_q.push_back(exp_vec(e / 4, 1, 0, 1'b0, 0));
      @(posedge clk); #1;
      got = obs(); ev = sb_q.pop_front(); n_checks++;
      if (got !== ev) begin
        n_errors++;
        $display("FAIL fill edge=%0d got=%h exp=%h", e, got, ev);
      end
    end
    water = 1'b0;
    $display("test_fill done");
  endtask

  task automatic test_overflow_drain();
    int lvl;
    do_reset();
    load = 2'd3; water = 1'b1;
    for (int e = 1; e <= 52; e++) begin
      lvl = e / 4;
      if (lvl > 12) lvl = 12;
      sb_q.push_back(exp_vec(lvl, 3, 0, 1'b0, (e >= 52) ? 1 : 0));
      @(posedge clk); #1;
      got = obs(); ev = sb_q.pop_front(); n_checks++;
      if (got !== ev) begin
        n_errors++;
        $display("FAIL overflow edge=%0d got=%h exp=%h", e, got, ev);
      end
    end
    water = 1'b0; pump = 1'b1;
    for (int e = 1; e <= 26; e++) begin
      lvl = 12 - e / 2;
      if (lvl < 0) lvl = 0;
      sb_q.push_back(exp_vec(lvl, 3, 0, 1'b0, 1));
      @(posedge clk); #1;
      got = obs(); ev = sb_q.pop_front(); n_checks++;
      if (got !== ev) begin
        n_errors++;
        $display("FAIL drain edge=%0d got=%h exp=%h", e, got, ev);
      end
    end
    pump = 1'b0;
    $display("test_overflow_drain done");
  endtask

  task automatic test_hold();
    do_reset();
    load = 2'd1;
    fill_edges(24);
    water = 1'b1; pump = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      if (e == 21) pump = 1'b0;
      // Fill resumes on the fourth edge after pump is released.
      sb_q.push_back(exp_vec((e >= 24) ? 7 : 6, 1, 0, 1'b0, 0));
      @(posedge clk); #1;
      got = obs(); ev = sb_q.pop_front(); n_checks++;
      if (got !== ev) begin
        n_errors++;
        $display("FAIL hold edge=%0d got=%h exp=%h", e, got, ev);
      end
    end
    water = 1'b0;
    $display("test_hold done");
  endtask

  task automatic test_spin();
    do_reset();
    load = 2'd0; motor = 1'b1; agitator = 1'b0; speed = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      sb_q.push_back(exp_vec(0, 0, (e >= 9) ? 3 : 2, 1'b0, 0));
      @(posedge clk); #1;
      got = obs(); ev = sb_q.pop_front(); n_checks++;
      if (got !== ev) begin
        n_errors++;
        $display("FAIL spin_lo edge=%0d got=%h exp=%h", e, got, ev);
      end
    end
    speed = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      sb_q.push_back(exp_vec(0, 0, (e >= 9) ? 3 : 2, 1'b1, 0));
      @(posedge clk); #1;
      got = obs(); ev = sb_q.pop_front(); n_checks++;
      if (got !== ev) begin
        n_errors++;
        $display("FAIL spin_hi edge=%0d got=%h exp=%h", e, got, ev);
      end
    end
    // Agitate, stop, then a fresh ramp relatches speed.
    for (int e = 1; e <= 3; e++) begin
      case (e)
        1: begin agitator = 1'b1; sb_q.push_back(exp_vec(0, 0, 1, 1'b1, 0)); end
        2: begin motor = 1'b0; sb_q.push_back(exp_vec(0, 0, 0, 1'b1, 0)); end
        default: begin
          motor = 1'b1; agitator = 1'b0; speed = 1'b0;
          sb_q.push_back(exp_vec(0, 0, 2, 1'b0, 0));
        end
      endcase
      @(posedge clk); #1;
      got = obs(); ev = sb_q.pop_front(); n_checks++;
      if (got !== ev) begin
        n_errors++;
        $display("FAIL drum_mode step=%0d got=%h exp=%h", e, got, ev);
      end
    end
    drive_idle();
    $display("test_spin done");
  endtask

  task automatic test_wet_spin_reset();
    do_reset();
    load = 2'd1;
    fill_edges(20);
    motor = 1'b1; agitator = 1'b0; speed = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      sb_q.push_back(exp_vec(5, 1, (e >= 9) ? 3 : 2, 1'b0, (e >= 9) ? 2 : 0));
      @(posedge clk); #1;
      got = obs(); ev = sb_q.pop_front(); n_checks++;
      if (got !== ev) begin
        n_errors++;
        $display("FAIL wet_spin edge=%0d got=%h exp=%h", e, got, ev);
      end
    end
    reset = 1'b1;
    sb_q.push_back(exp_vec(0, 1, 0, 1'b0, 0));
    @(posedge clk); #1;
    reset = 1'b0;
    got = obs(); ev = sb_q.pop_front(); n_checks++;
    if (got !== ev) begin
      n_errors++;
      $display("FAIL mid_reset got=%h exp=%h", got, ev);
    end
    drive_idle();
    $display("test_wet_spin_reset done");
  endtask

`ifdef WASHER_PLANT_LEAK_EN
  task automatic test_leak();
    int lvl;
    do_reset();
    load = 2'd3;
    fill_edges(16);
    for (int e = 17; e <= 96; e++) begin
      water = (e >= 81);
      if (e <= 80)      lvl = 4 - ((e >= 32) ? 1 : 0) - ((e >= 64) ? 1 : 0);
      else if (e < 84)  lvl = 2;
      else if (e < 88)  lvl = 3;
      else if (e < 92)  lvl = 4;
      else              lvl = 5;
      sb_q.push_back(exp_vec(lvl, 3, 0, 1'b0, 0));
      @(posedge clk); #1;
      got = obs(); ev = sb_q.pop_front(); n_checks++;
      if (got !== ev) begin
        n_errors++;
        $display("FAIL leak edge=%0d got=%h exp=%h", e, got, ev);
      end
    end
    drive_idle();
    $display("test_leak done");
  endtask
`endif

  initial begin
    @(posedge clk); #1;
    test_reset();
`ifdef WASHER_PLANT_LEAK_EN
    test_spin();
    test_leak();
`else
    test_fill();
    test_overflow_drain();
    test_hold();
    test_spin();
    test_wet_spin_reset();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
